pre_quant_lanes: RTL
====================

PRE_QUANT_LANES -- requirements
Module: pre_quant_lanes

Interface
REQ-001 Parameter DATA_W, default 32, signed width of input coefficients, output coefficients and Y_QMAT/C_QMAT entries.
REQ-002 Parameter QSCALE_W, default 8, unsigned width of QSCALE.
REQ-003 Parameter LANES, default 8, coefficients quantised per cycle; legal values 1,2,4,8,16,32,64; any other value SHALL fail elaboration.
REQ-004 CLOCK  input  1  clock, all state on rising edge.
REQ-005 RESET  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  input block valid.
REQ-007 in_ready  output  1  block can be accepted.
REQ-008 INPUT_DATA  input  [8][8] x DATA_W signed  DCT coefficients.
REQ-009 QSCALE  input  QSCALE_W unsigned  quantiser scale.
REQ-010 is_y  input  1  1 selects Y_QMAT, 0 selects C_QMAT.
REQ-011 Y_QMAT, C_QMAT  input  [8][8] x DATA_W signed  quantisation matrices, static while busy.
REQ-012 out_valid  output  1  OUTPUT_DATA holds a complete block.
REQ-013 out_ready  input  1  downstream accepts block.
REQ-014 OUTPUT_DATA  output  [8][8] x DATA_W signed  quantised coefficients.
REQ-015 div_zero_err  output  1  sticky divide-by-zero flag.

Function
REQ-016 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on in_valid&&in_ready, capture INPUT_DATA, QSCALE, is_y into internal registers, clear group counter, go to CALC.
REQ-018 CALC: with N=64/LANES, each cycle quantise LANES coefficients at raster indices g*LANES..g*LANES+LANES-1 (index = row*8+col) using captured operands, g = group counter 0..N-1, and write them into OUTPUT_DATA.
REQ-019 CALC: after group N-1 is written, go to DONE and set out_valid on the same edge; acceptance at edge k gives out_valid visible after edge k+N.
REQ-020 DONE: hold OUTPUT_DATA and out_valid=1 until out_ready=1; on that edge clear out_valid and go to IDLE; in_ready rises on the following cycle (no same-cycle accept).
REQ-021 Input changes after acceptance SHALL NOT affect the block in flight.
REQ-022 Arithmetic: n = x<<2 computed in DATA_W+2 bits signed; d = QSCALE * qmat computed in DATA_W+QSCALE_W+1 bits signed; q = n/d, truncation toward zero.
REQ-023 q SHALL saturate to the DATA_W signed range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-024 If d==0, that coefficient SHALL be 0 and div_zero_err SHALL be set; it stays 1 until reset.
REQ-025 OUTPUT_DATA entries not yet written in CALC retain their previous block values.

Reset
REQ-026 RESET==0 at any edge, including mid-CALC or DONE: state IDLE, group counter 0, out_valid 0, all OUTPUT_DATA 0, div_zero_err 0, in-flight block discarded.
REQ-027 in_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-028 Macro PRE_QUANT_ROUND_EN defined: q = sign(n)*((|n| + |d|/2) / |d|), rounding half away from zero, then REQ-023 saturation applies.
REQ-029 PRE_QUANT_ROUND_EN undefined: truncation toward zero per REQ-022; latency and handshake are identical in both builds.

Verification
REQ-030 LANES=8, all x=4, QSCALE=2, Y_QMAT all 3, is_y=1 -> out_valid 8 edges after accept; all outputs 2 (3 with PRE_QUANT_ROUND_EN).
REQ-031 x=-4 everywhere, same matrices -> all outputs -2 (-3 with PRE_QUANT_ROUND_EN); x=5 -> 3 in both builds.
REQ-032 is_y=0, C_QMAT[0][0]=0, others 1, QSCALE=1, x=7 -> OUTPUT_DATA[0][0]=0, others 28, div_zero_err=1 until reset.
REQ-033 x[0][0]=2^31-1, QSCALE=1, qmat=1 -> OUTPUT_DATA[0][0]=2^31-1; x[0][1]=-2^31 -> -2^31.
REQ-034 out_ready held 0 for 5 cycles after out_valid -> OUTPUT_DATA stable, in_ready 0, new in_valid ignored; out_ready=1 -> in_ready 1 next cycle; repeat with LANES=1 (latency 64) and LANES=64 (latency 1).
REQ-035 RESET=0 during CALC group 3 -> next cycle out_valid 0, OUTPUT_DATA all 0, in_ready 1; subsequent block processed correctly.

Source files
------------

// File: rtl/pre_quant_lanes.sv
// Block pre-quantiser: captures an 8x8 coefficient block, divides LANES coefficients per
// cycle by QSCALE*qmat with saturation. Define PRE_QUANT_ROUND_EN for round-half-away-from-zero.
module pre_quant_lanes #(
    parameter int DATA_W   = 32,
    parameter int QSCALE_W = 8,
    parameter int LANES    = 8
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] INPUT_DATA [0:7][0:7],
    input  logic [QSCALE_W-1:0]      QSCALE,
    input  logic                     is_y,
    input  logic signed [DATA_W-1:0] Y_QMAT [0:7][0:7],
    input  logic signed [DATA_W-1:0] C_QMAT [0:7][0:7],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] OUTPUT_DATA [0:7][0:7],
    output logic                     div_zero_err
);

    localparam int N  = 64 / LANES;
    localparam int DW = DATA_W + QSCALE_W + 1;
    // Two guard bits so |n| + |d|/2 can never overflow the working width.
    localparam int WW = DW + 2;
    localparam logic signed [WW-1:0] QMAX = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WW-1:0] QMIN = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
        $error("pre_quant_lanes: LANES must be a power of two between 1 and 64");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                     state_q, state_d;
    logic [5:0]                 grp_q, grp_d;
    logic                       out_valid_q, out_valid_d;
    logic                       dz_q, dz_d;
    logic                       is_y_q, is_y_d;
    logic [QSCALE_W-1:0]        qscale_q, qscale_d;
    logic signed [DATA_W-1:0]   x_q [64];
    logic signed [DATA_W-1:0]   x_d [64];
    logic signed [DATA_W-1:0]   res_q [64];
    logic signed [DATA_W-1:0]   res_d [64];

    logic signed [DATA_W-1:0]   lane_val [LANES];
    logic [5:0]                 lane_idx [LANES];
    logic [LANES-1:0]           lane_dz;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [DATA_W-1:0] qm;
        logic signed [DW-1:0]     qs_e, qm_e, dprod;
        logic signed [WW-1:0]     n_w, d_w, q_w, q_sat;
        logic                     dz_l;

        assign lane_idx[gi] = 6'(32'(grp_q) * LANES + gi);
        assign qm = is_y_q ? Y_QMAT[lane_idx[gi][5:3]][lane_idx[gi][2:0]]
                           : C_QMAT[lane_idx[gi][5:3]][lane_idx[gi][2:0]];

`ifdef PRE_QUANT_ROUND_EN
        logic signed [WW-1:0] an, ad, mag;
`endif

        always_comb begin
            n_w   = WW'(x_q[lane_idx[gi]]) <<< 2;
            qs_e  = DW'({1'b0, qscale_q});
            qm_e  = DW'(qm);
            dprod = qs_e * qm_e;
            d_w   = WW'(dprod);
            dz_l  = (d_w == '0);
`ifdef PRE_QUANT_ROUND_EN
            an  = n_w[WW-1] ? -n_w : n_w;
            ad  = d_w[WW-1] ? -d_w : d_w;
            mag = '0;
            q_w = '0;
            if (!dz_l) begin
                mag = (an + (ad >>> 1)) / ad;
                q_w = n_w[WW-1] ? -mag : mag;
            end
`else
            q_w = '0;
            if (!dz_l) begin
                q_w = n_w / d_w;
            end
`endif
            if (q_w > QMAX)
                q_sat = QMAX;
            else if (q_w < QMIN)
                q_sat = QMIN;
            else
                q_sat = q_w;
        end

        assign lane_val[gi] = q_sat[DATA_W-1:0];
        assign lane_dz[gi]  = dz_l;
    end

    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        out_valid_d = out_valid_q;
        dz_d        = dz_q;
        is_y_d      = is_y_q;
        qscale_d    = qscale_q;
        for (int i = 0; i < 64; i++) begin
            x_d[i]   = x_q[i];
            res_d[i] = res_q[i];
        end
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < 64; i++)
                        x_d[i] = INPUT_DATA[i/8][i%8];
                    qscale_d = QSCALE;
                    is_y_d   = is_y;
                    grp_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                for (int li = 0; li < LANES; li++)
                    res_d[lane_idx[li]] = lane_val[li];
                if (|lane_dz)
                    dz_d = 1'b1;
                if (grp_q == 6'(N - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    grp_d = grp_q + 6'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            grp_q       <= '0;
            out_valid_q <= 1'b0;
            dz_q        <= 1'b0;
            is_y_q      <= 1'b0;
            qscale_q    <= '0;
            for (int i = 0; i < 64; i++) begin
                x_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            out_valid_q <= out_valid_d;
            dz_q        <= dz_d;
            is_y_q      <= is_y_d;
            qscale_q    <= qscale_d;
            for (int i = 0; i < 64; i++) begin
                x_q[i]   <= x_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_out
        assign OUTPUT_DATA[gi/8][gi%8] = res_q[gi];
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = out_valid_q;
    assign div_zero_err = dz_q;

endmodule
